// File: rtl/pf_icache_ctrl_pkg.sv
// Shared definitions for the prefetching I-cache control front-end:
// register offsets, STATUS bit positions, FSM state and command kinds.
package pf_icache_ctrl_pkg;

    localparam logic [9:0] REG_ENABLE    = 10'h000;
    localparam logic [9:0] REG_FLUSH     = 10'h004;
    localparam logic [9:0] REG_SEL_FLUSH = 10'h008;
    localparam logic [9:0] REG_PF_ADDR   = 10'h00C;
    localparam logic [9:0] REG_PF_SIZE   = 10'h010;
    localparam logic [9:0] REG_STATUS    = 10'h014;
    localparam logic [9:0] REG_STAT_CTRL = 10'h018;
    localparam logic [9:0] REG_GLB_HIT   = 10'h020;
    localparam logic [9:0] REG_GLB_TRANS = 10'h024;
    localparam logic [9:0] REG_GLB_MISS  = 10'h028;
    localparam logic [9:0] REG_GLB_CONG  = 10'h02C;

    // Bank b occupies a 16-byte window starting at BANK_BASE + 16*b
    localparam logic [9:0] BANK_BASE     = 10'h040;

    localparam int STATUS_BUSY_BIT        = 0;
    localparam int STATUS_PF_DONE_BIT     = 1;
    localparam int STATUS_BYP_SETTLED_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYP_WAIT,
        ST_FLUSH_WAIT,
        ST_SFLUSH_WAIT,
        ST_PF_REQ,
        ST_PF_WAIT
    } state_e;

    typedef enum logic [1:0] {
        CMD_ENABLE,
        CMD_FLUSH,
        CMD_SEL_FLUSH,
        CMD_PF
    } cmd_e;

endpackage

// File: rtl/pf_icache_ctrl_if.sv
// Single-beat peripheral bus: request channel plus one-cycle-later response.
interface pf_icache_ctrl_if #(
    parameter int ID_WIDTH = 9
);
    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [31:0]         wdata;
    logic [3:0]          be;
    logic [ID_WIDTH-1:0] id;
    logic                gnt;
    logic                r_valid;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_rdata;

    modport master (
        output req, add, wen, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );

    modport slave (
        input  req, add, wen, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface

// File: rtl/pf_icache_ctrl_cmd_fsm.sv
// Command FSM: turns one accepted command strobe into the matching held-level
// handshake towards the cache and reports when a prefetch completes.
module pf_icache_ctrl_cmd_fsm
    import pf_icache_ctrl_pkg::*;
#(
    parameter int NB_CORES      = 8,
    parameter int PF_SIZE_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    input  cmd_e                     cmd_kind_i,
    input  logic [31:0]              cmd_data_i,
    input  logic [31:0]              pf_addr_i,
    input  logic [NB_CORES:0]        bypass_ack_i,
    input  logic                     flush_ack_i,
    input  logic                     sel_flush_ack_i,
    input  logic                     pf_ack_i,
    input  logic                     pf_done_i,
    output logic                     busy_o,
    output logic                     bypass_settled_o,
    output logic                     pf_done_set_o,
    output logic                     bypass_req_o,
    output logic                     flush_req_o,
    output logic                     sel_flush_req_o,
    output logic [31:0]              sel_flush_addr_o,
    output logic                     pf_req_o,
    output logic [31:0]              pf_addr_o,
    output logic [PF_SIZE_WIDTH-1:0] pf_size_o
);

    state_e                   state_q, state_d;
    logic                     bypassReq_q, bypassReq_d;
    logic [31:0]              selFlushAddr_q, selFlushAddr_d;
    logic [31:0]              pfAddr_q, pfAddr_d;
    logic [PF_SIZE_WIDTH-1:0] pfSize_q, pfSize_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            bypassReq_q    <= 1'b1;
            selFlushAddr_q <= '0;
            pfAddr_q       <= '0;
            pfSize_q       <= '0;
        end else begin
            state_q        <= state_d;
            bypassReq_q    <= bypassReq_d;
            selFlushAddr_q <= selFlushAddr_d;
            pfAddr_q       <= pfAddr_d;
            pfSize_q       <= pfSize_d;
        end
    end

    assign bypass_settled_o = (bypass_ack_i == {(NB_CORES + 1){bypassReq_q}});

    // Command payloads are captured only on entry, so they stay stable for the whole handshake
    always_comb begin
        state_d        = state_q;
        bypassReq_d    = bypassReq_q;
        selFlushAddr_d = selFlushAddr_q;
        pfAddr_d       = pfAddr_q;
        pfSize_d       = pfSize_q;
        pf_done_set_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_kind_i)
                        CMD_ENABLE: begin
                            state_d     = ST_BYP_WAIT;
                            bypassReq_d = ~cmd_data_i[0];
                        end
                        CMD_FLUSH: state_d = ST_FLUSH_WAIT;
                        CMD_SEL_FLUSH: begin
                            state_d        = ST_SFLUSH_WAIT;
                            selFlushAddr_d = cmd_data_i;
                        end
                        CMD_PF: begin
                            state_d  = ST_PF_REQ;
                            pfAddr_d = pf_addr_i;
                            pfSize_d = cmd_data_i[PF_SIZE_WIDTH-1:0];
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_BYP_WAIT:    if (bypass_settled_o) state_d = ST_IDLE;
            ST_FLUSH_WAIT:  if (flush_ack_i) state_d = ST_IDLE;
            ST_SFLUSH_WAIT: if (sel_flush_ack_i) state_d = ST_IDLE;
            ST_PF_REQ: begin
                if (pf_ack_i && pf_done_i) begin
                    state_d       = ST_IDLE;
                    pf_done_set_o = 1'b1;
                end else if (pf_ack_i) begin
                    state_d = ST_PF_WAIT;
                end
            end
            ST_PF_WAIT: begin
                if (pf_done_i) begin
                    state_d       = ST_IDLE;
                    pf_done_set_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign bypass_req_o     = bypassReq_q;
    assign flush_req_o      = (state_q == ST_FLUSH_WAIT);
    assign sel_flush_req_o  = (state_q == ST_SFLUSH_WAIT);
    assign sel_flush_addr_o = selFlushAddr_q;
    assign pf_req_o         = (state_q == ST_PF_REQ);
    assign pf_addr_o        = pfAddr_q;
    assign pf_size_o        = pfSize_q;

endmodule

// File: rtl/pf_icache_ctrl_unit.sv
// Peripheral-bus register front-end of the prefetching I-cache: address decode,
// grant/back-pressure, registered response and the statistics read mux.
module pf_icache_ctrl_unit
    import pf_icache_ctrl_pkg::*;
#(
    parameter int NB_CORES      = 8,
    parameter int NB_BANKS      = 8,
    parameter int ID_WIDTH      = NB_CORES + 1,
    parameter int CNT_WIDTH     = 32,
    parameter int PF_SIZE_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    pf_icache_ctrl_if.slave               bus,
    output logic                          bypass_req_o,
    input  logic [NB_CORES:0]             bypass_ack_i,
    output logic                          flush_req_o,
    input  logic                          flush_ack_i,
    output logic                          sel_flush_req_o,
    output logic [31:0]                   sel_flush_addr_o,
    input  logic                          sel_flush_ack_i,
    output logic                          pf_req_o,
    output logic [31:0]                   pf_addr_o,
    output logic [PF_SIZE_WIDTH-1:0]      pf_size_o,
    input  logic                          pf_ack_i,
    input  logic                          pf_done_i,
    input  logic [CNT_WIDTH-1:0]          global_hit_cnt_i,
    input  logic [CNT_WIDTH-1:0]          global_trans_cnt_i,
    input  logic [CNT_WIDTH-1:0]          global_miss_cnt_i,
    input  logic [CNT_WIDTH-1:0]          global_cong_cnt_i,
    input  logic [NB_BANKS*CNT_WIDTH-1:0] bank_hit_cnt_i,
    input  logic [NB_BANKS*CNT_WIDTH-1:0] bank_trans_cnt_i,
    input  logic [NB_BANKS*CNT_WIDTH-1:0] bank_miss_cnt_i,
    input  logic [NB_BANKS*CNT_WIDTH-1:0] bank_cong_cnt_i,
    output logic                          ctrl_enable_regs_o,
    output logic                          ctrl_clear_regs_o
);

    localparam logic [10:0] BANK_END = 11'(BANK_BASE) + 11'(16 * NB_BANKS);

    logic [9:0]           byteOff, bankRel;
    logic [3:0]           bankIdx;
    logic                 inBank;
    logic [CNT_WIDTH-1:0] bankCnt;
    logic [31:0]          readData, statusWord;
    logic                 decErr, isCmd, cmdWrite, accept, wrAccept, rdAccept, cmdStrobe;
    cmd_e                 cmdKind;
    logic                 busy, bypassSettled, pfDoneSet;
    logic                 unusedBits;

    logic                rValid_q, rValid_d;
    logic                rOpc_q, rOpc_d;
    logic [ID_WIDTH-1:0] rId_q, rId_d;
    logic [31:0]         rData_q, rData_d;
    logic [31:0]         pfAddrReg_q, pfAddrReg_d;
    logic                statEnable_q, statEnable_d;
    logic                statClear_q, statClear_d;
    logic                pfDoneSticky_q, pfDoneSticky_d;

    assign byteOff    = {bus.add[9:2], 2'b00};
    assign bankRel    = byteOff - BANK_BASE;
    assign bankIdx    = bankRel[7:4];
    assign inBank     = (byteOff >= BANK_BASE) && ({1'b0, byteOff} < BANK_END);
    assign unusedBits = ^{bus.be, bus.add[31:10], bus.add[1:0], bankRel[9:8], bankRel[1:0]};

    always_comb begin
        bankCnt = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            if (bankIdx == 4'(b)) begin
                case (bankRel[3:2])
                    2'd0:    bankCnt = bank_hit_cnt_i[b*CNT_WIDTH +: CNT_WIDTH];
                    2'd1:    bankCnt = bank_trans_cnt_i[b*CNT_WIDTH +: CNT_WIDTH];
                    2'd2:    bankCnt = bank_miss_cnt_i[b*CNT_WIDTH +: CNT_WIDTH];
                    default: bankCnt = bank_cong_cnt_i[b*CNT_WIDTH +: CNT_WIDTH];
                endcase
            end
        end
    end

    always_comb begin
        statusWord                         = '0;
        statusWord[STATUS_BUSY_BIT]        = busy;
        statusWord[STATUS_PF_DONE_BIT]     = pfDoneSticky_q;
        statusWord[STATUS_BYP_SETTLED_BIT] = bypassSettled;
    end

    // A zero-length prefetch is rejected at decode so it never reaches the FSM
    always_comb begin
        readData = '0;
        decErr   = 1'b0;
        isCmd    = 1'b0;
        cmdKind  = CMD_ENABLE;
        if (inBank) begin
            readData = 32'(bankCnt);
        end else begin
            case (byteOff)
                REG_ENABLE: begin
                    readData[0] = ~bypass_req_o;
                    isCmd       = 1'b1;
                end
                REG_FLUSH: begin
                    isCmd   = 1'b1;
                    cmdKind = CMD_FLUSH;
                end
                REG_SEL_FLUSH: begin
                    readData = sel_flush_addr_o;
                    isCmd    = 1'b1;
                    cmdKind  = CMD_SEL_FLUSH;
                end
                REG_PF_ADDR: readData = pfAddrReg_q;
                REG_PF_SIZE: begin
                    readData = 32'(pf_size_o);
                    isCmd    = 1'b1;
                    cmdKind  = CMD_PF;
                    decErr   = ~bus.wen && (bus.wdata[PF_SIZE_WIDTH-1:0] == '0);
                end
                REG_STATUS:    readData = statusWord;
                REG_STAT_CTRL: readData[0] = statEnable_q;
                REG_GLB_HIT:   readData = 32'(global_hit_cnt_i);
                REG_GLB_TRANS: readData = 32'(global_trans_cnt_i);
                REG_GLB_MISS:  readData = 32'(global_miss_cnt_i);
                REG_GLB_CONG:  readData = 32'(global_cong_cnt_i);
                default:       decErr = 1'b1;
            endcase
        end
    end

    assign cmdWrite  = bus.req && !bus.wen && isCmd;
    assign bus.gnt   = bus.req && !(cmdWrite && busy);
    assign accept    = bus.req && bus.gnt;
    assign wrAccept  = accept && !bus.wen;
    assign rdAccept  = accept && bus.wen;
    assign cmdStrobe = wrAccept && isCmd && !decErr;

    pf_icache_ctrl_cmd_fsm #(
        .NB_CORES      (NB_CORES),
        .PF_SIZE_WIDTH (PF_SIZE_WIDTH)
    ) u_cmd_fsm (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cmd_valid_i      (cmdStrobe),
        .cmd_kind_i       (cmdKind),
        .cmd_data_i       (bus.wdata),
        .pf_addr_i        (pfAddrReg_q),
        .bypass_ack_i     (bypass_ack_i),
        .flush_ack_i      (flush_ack_i),
        .sel_flush_ack_i  (sel_flush_ack_i),
        .pf_ack_i         (pf_ack_i),
        .pf_done_i        (pf_done_i),
        .busy_o           (busy),
        .bypass_settled_o (bypassSettled),
        .pf_done_set_o    (pfDoneSet),
        .bypass_req_o     (bypass_req_o),
        .flush_req_o      (flush_req_o),
        .sel_flush_req_o  (sel_flush_req_o),
        .sel_flush_addr_o (sel_flush_addr_o),
        .pf_req_o         (pf_req_o),
        .pf_addr_o        (pf_addr_o),
        .pf_size_o        (pf_size_o)
    );

    // Sticky done: a completion in the same cycle as a STATUS read survives the read
    always_comb begin
        rValid_d       = accept;
        rOpc_d         = rOpc_q;
        rId_d          = rId_q;
        rData_d        = rData_q;
        if (accept) begin
            rOpc_d  = decErr;
            rId_d   = bus.id;
            rData_d = decErr ? 32'h0 : readData;
        end
        pfAddrReg_d    = (wrAccept && !inBank && byteOff == REG_PF_ADDR) ? bus.wdata : pfAddrReg_q;
        statEnable_d   = statEnable_q;
        statClear_d    = 1'b0;
        if (wrAccept && !inBank && byteOff == REG_STAT_CTRL) begin
            statEnable_d = bus.wdata[0];
            statClear_d  = bus.wdata[1];
        end
        pfDoneSticky_d = pfDoneSet ||
                         (pfDoneSticky_q && !(rdAccept && !inBank && byteOff == REG_STATUS));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rValid_q       <= 1'b0;
            rOpc_q         <= 1'b0;
            rId_q          <= '0;
            rData_q        <= '0;
            pfAddrReg_q    <= '0;
            statEnable_q   <= 1'b0;
            statClear_q    <= 1'b0;
            pfDoneSticky_q <= 1'b0;
        end else begin
            rValid_q       <= rValid_d;
            rOpc_q         <= rOpc_d;
            rId_q          <= rId_d;
            rData_q        <= rData_d;
            pfAddrReg_q    <= pfAddrReg_d;
            statEnable_q   <= statEnable_d;
            statClear_q    <= statClear_d;
            pfDoneSticky_q <= pfDoneSticky_d;
        end
    end

    assign bus.r_valid        = rValid_q;
    assign bus.r_opc          = rOpc_q;
    assign bus.r_id           = rId_q;
    assign bus.r_rdata        = rData_q;
    assign ctrl_enable_regs_o = statEnable_q;
    assign ctrl_clear_regs_o  = statClear_q;

endmodule

// File: tb/tb_pf_icache_ctrl_unit.sv
// Directed self-checking bench for pf_icache_ctrl_unit with hand-computed
// expectations for each register access and handshake sequence.
module tb_pf_icache_ctrl_unit;

    localparam int NB_CORES  = 8;
    localparam int NB_BANKS  = 8;
    localparam int ID_WIDTH  = 9;
    localparam int CNT_WIDTH = 32;
    localparam int PSW       = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          bypassReq;
    logic [NB_CORES:0]             bypassAck;
    logic                          flushReq, flushAck;
    logic                          selFlushReq, selFlushAck;
    logic [31:0]                   selFlushAddr;
    logic                          pfReq, pfAck, pfDone;
    logic [31:0]                   pfAddr;
    logic [PSW-1:0]                pfSize;
    logic [CNT_WIDTH-1:0]          glbHit, glbTrans, glbMiss, glbCong;
    logic [NB_BANKS*CNT_WIDTH-1:0] bankHit, bankTrans, bankMiss, bankCong;
    logic                          statEnable, statClear;

    int checkCount = 0;
    int passCount  = 0;

    logic        opc;
    logic [31:0] rd;

    always #5 clk = ~clk;

    pf_icache_ctrl_if #(.ID_WIDTH(ID_WIDTH)) bus ();

    pf_icache_ctrl_unit #(
        .NB_CORES      (NB_CORES),
        .NB_BANKS      (NB_BANKS),
        .ID_WIDTH      (ID_WIDTH),
        .CNT_WIDTH     (CNT_WIDTH),
        .PF_SIZE_WIDTH (PSW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .bus                (bus),
        .bypass_req_o       (bypassReq),
        .bypass_ack_i       (bypassAck),
        .flush_req_o        (flushReq),
        .flush_ack_i        (flushAck),
        .sel_flush_req_o    (selFlushReq),
        .sel_flush_addr_o   (selFlushAddr),
        .sel_flush_ack_i    (selFlushAck),
        .pf_req_o           (pfReq),
        .pf_addr_o          (pfAddr),
        .pf_size_o          (pfSize),
        .pf_ack_i           (pfAck),
        .pf_done_i          (pfDone),
        .global_hit_cnt_i   (glbHit),
        .global_trans_cnt_i (glbTrans),
        .global_miss_cnt_i  (glbMiss),
        .global_cong_cnt_i  (glbCong),
        .bank_hit_cnt_i     (bankHit),
        .bank_trans_cnt_i   (bankTrans),
        .bank_miss_cnt_i    (bankMiss),
        .bank_cong_cnt_i    (bankCong),
        .ctrl_enable_regs_o (statEnable),
        .ctrl_clear_regs_o  (statClear)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Called one time unit after a rising edge; returns one unit after the response edge
    task automatic applyStimulus(input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [ID_WIDTH-1:0] id,
                                 output logic rOpc, output logic [31:0] rData);
        int waitCycles;
        bus.req   = 1'b1;
        bus.wen   = wen;
        bus.add   = addr;
        bus.wdata = wdata;
        bus.id    = id;
        bus.be    = 4'hF;
        #1;
        waitCycles = 0;
        while (bus.gnt !== 1'b1 && waitCycles < 64) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (bus.gnt !== 1'b1) checkOutput("grant timeout", {31'b0, bus.gnt}, 32'h1);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        checkOutput("r_valid", {31'b0, bus.r_valid}, 32'h1);
        checkOutput("r_id", 32'(bus.r_id), 32'(id));
        rOpc  = bus.r_opc;
        rData = bus.r_rdata;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bypassAck = '0; flushAck = 1'b0; selFlushAck = 1'b0; pfAck = 1'b0; pfDone = 1'b0;
        glbHit = 32'h11; glbTrans = 32'h22; glbMiss = 32'h1234; glbCong = 32'h44;
        bankHit = '0; bankTrans = '0; bankMiss = '0; bankCong = '0;
        bankHit[3*CNT_WIDTH +: CNT_WIDTH]  = 32'hDEAD;
        bankHit[2*CNT_WIDTH +: CNT_WIDTH]  = 32'h5555;
        bankCong[7*CNT_WIDTH +: CNT_WIDTH] = 32'hBEEF;
        bus.req = 1'b0; bus.wen = 1'b1; bus.add = '0; bus.wdata = '0; bus.be = '0; bus.id = '0;
        repeat (3) nextCycle();

        checkOutput("reset bypass_req", {31'b0, bypassReq}, 32'h1);
        checkOutput("reset flush_req", {31'b0, flushReq}, 32'h0);
        checkOutput("reset pf_req", {31'b0, pfReq}, 32'h0);
        checkOutput("reset r_valid", {31'b0, bus.r_valid}, 32'h0);
        checkOutput("reset ctrl_enable", {31'b0, statEnable}, 32'h0);
        rst = 1'b0;
        nextCycle();

        // Enable the cache and walk the bypass acknowledge handshake
        applyStimulus(1'b1, 32'h00, 32'h0, 9'd1, opc, rd);
        checkOutput("ENABLE rd after reset", rd, 32'h0);
        checkOutput("ENABLE rd opc", {31'b0, opc}, 32'h0);
        bypassAck = 9'h1FF;
        applyStimulus(1'b0, 32'h00, 32'h1, 9'd2, opc, rd);
        checkOutput("bypass_req after enable", {31'b0, bypassReq}, 32'h0);
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd3, opc, rd);
        checkOutput("STATUS in BYP_WAIT", rd, 32'h1);
        repeat (2) nextCycle();
        bypassAck = 9'h000;
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd4, opc, rd);
        checkOutput("STATUS acks just matched", rd, 32'h5);
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd5, opc, rd);
        checkOutput("STATUS after BYP_WAIT", rd, 32'h4);
        applyStimulus(1'b1, 32'h00, 32'h0, 9'd6, opc, rd);
        checkOutput("ENABLE rd enabled", rd, 32'h1);
        bypassAck = 9'h001;

        // Full flush, with a second flush back-pressured until the first completes
        applyStimulus(1'b0, 32'h04, 32'h0, 9'd7, opc, rd);
        bus.req = 1'b1; bus.wen = 1'b0; bus.add = 32'h04; bus.wdata = 32'h0; bus.id = 9'd8;
        #1;
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("flush_req cycle %0d", c), {31'b0, flushReq}, 32'h1);
            checkOutput($sformatf("2nd flush gnt cycle %0d", c), {31'b0, bus.gnt}, 32'h0);
            if (c == 4) flushAck = 1'b1;
            nextCycle();
        end
        flushAck = 1'b0;
        checkOutput("flush_req after ack", {31'b0, flushReq}, 32'h0);
        checkOutput("2nd flush granted", {31'b0, bus.gnt}, 32'h1);
        nextCycle();
        bus.req = 1'b0;
        checkOutput("2nd flush r_valid", {31'b0, bus.r_valid}, 32'h1);
        checkOutput("2nd flush r_id", 32'(bus.r_id), 32'd8);
        checkOutput("2nd flush_req", {31'b0, flushReq}, 32'h1);
        flushAck = 1'b1;
        nextCycle();
        flushAck = 1'b0;
        checkOutput("2nd flush done", {31'b0, flushReq}, 32'h0);

        // Prefetch: ack at cycle 2, done at cycle 7 together with a STATUS read
        applyStimulus(1'b0, 32'h0C, 32'h1C00_0000, 9'd9, opc, rd);
        applyStimulus(1'b1, 32'h0C, 32'h0, 9'd10, opc, rd);
        checkOutput("PF_ADDR rd", rd, 32'h1C00_0000);
        applyStimulus(1'b0, 32'h10, 32'h4, 9'd11, opc, rd);
        checkOutput("pf_req cycle 1", {31'b0, pfReq}, 32'h1);
        checkOutput("pf_addr", pfAddr, 32'h1C00_0000);
        checkOutput("pf_size", 32'(pfSize), 32'h4);
        nextCycle();
        pfAck = 1'b1;
        checkOutput("pf_req cycle 2", {31'b0, pfReq}, 32'h1);
        nextCycle();
        pfAck = 1'b0;
        checkOutput("pf_req after ack", {31'b0, pfReq}, 32'h0);
        repeat (4) nextCycle();
        pfDone = 1'b1;
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd12, opc, rd);
        pfDone = 1'b0;
        checkOutput("STATUS with pf_done", rd, 32'h1);
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd13, opc, rd);
        checkOutput("STATUS sticky done", rd, 32'h2);
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd14, opc, rd);
        checkOutput("STATUS sticky cleared", rd, 32'h0);

        // Zero-size prefetch is rejected; then same-cycle ack and done
        applyStimulus(1'b0, 32'h10, 32'h0, 9'd15, opc, rd);
        checkOutput("PF_SIZE=0 opc", {31'b0, opc}, 32'h1);
        checkOutput("PF_SIZE=0 pf_req", {31'b0, pfReq}, 32'h0);
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd16, opc, rd);
        checkOutput("STATUS after PF_SIZE=0", rd, 32'h0);
        applyStimulus(1'b0, 32'h10, 32'h2, 9'd17, opc, rd);
        checkOutput("pf_req size 2", {31'b0, pfReq}, 32'h1);
        pfAck = 1'b1; pfDone = 1'b1;
        nextCycle();
        pfAck = 1'b0; pfDone = 1'b0;
        checkOutput("pf_req after ack+done", {31'b0, pfReq}, 32'h0);
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd18, opc, rd);
        checkOutput("STATUS after ack+done", rd, 32'h2);

        // Statistics windows and decode errors
        applyStimulus(1'b1, 32'h70, 32'h0, 9'd19, opc, rd);
        checkOutput("bank3 hit", rd, 32'hDEAD);
        applyStimulus(1'b1, 32'h60, 32'h0, 9'd20, opc, rd);
        checkOutput("bank2 hit", rd, 32'h5555);
        applyStimulus(1'b1, 32'hBC, 32'h0, 9'd21, opc, rd);
        checkOutput("bank7 cong", rd, 32'hBEEF);
        applyStimulus(1'b1, 32'h28, 32'h0, 9'd22, opc, rd);
        checkOutput("global miss", rd, 32'h1234);
        checkOutput("global miss opc", {31'b0, opc}, 32'h0);
        applyStimulus(1'b1, 32'hC0, 32'h0, 9'd23, opc, rd);
        checkOutput("bank8 opc", {31'b0, opc}, 32'h1);
        checkOutput("bank8 rdata", rd, 32'h0);
        applyStimulus(1'b1, 32'h1C, 32'h0, 9'd24, opc, rd);
        checkOutput("unmapped 0x1C opc", {31'b0, opc}, 32'h1);
        applyStimulus(1'b0, 32'h18, 32'h3, 9'd25, opc, rd);
        checkOutput("stat enable", {31'b0, statEnable}, 32'h1);
        checkOutput("stat clear pulse", {31'b0, statClear}, 32'h1);
        nextCycle();
        checkOutput("stat clear dropped", {31'b0, statClear}, 32'h0);
        applyStimulus(1'b1, 32'h18, 32'h0, 9'd26, opc, rd);
        checkOutput("STAT_CTRL rd", rd, 32'h1);

        // Reset in the middle of a selective flush with a response in flight
        applyStimulus(1'b0, 32'h08, 32'hABCD_0000, 9'd27, opc, rd);
        checkOutput("sel_flush_req", {31'b0, selFlushReq}, 32'h1);
        checkOutput("sel_flush_addr", selFlushAddr, 32'hABCD_0000);
        bus.req = 1'b1; bus.wen = 1'b1; bus.add = 32'h0C; bus.id = 9'd28;
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        bus.req = 1'b0;
        checkOutput("rst sel_flush_req", {31'b0, selFlushReq}, 32'h0);
        checkOutput("rst bypass_req", {31'b0, bypassReq}, 32'h1);
        checkOutput("rst r_valid", {31'b0, bus.r_valid}, 32'h0);
        checkOutput("rst sel_flush_addr", selFlushAddr, 32'h0);
        checkOutput("rst pf_addr", pfAddr, 32'h0);
        checkOutput("rst ctrl_enable", {31'b0, statEnable}, 32'h0);
        applyStimulus(1'b1, 32'h14, 32'h0, 9'd29, opc, rd);
        checkOutput("STATUS after rst", rd, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
